mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: OPC_W, 32, width of the opcode bus received from the execute stage.
REQ-002 Parameter: RD_W, 11, width of the destination-register tag.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rstl  input  1  asynchronous, active-low reset.
REQ-005 Port: valid_exe_2_mem_i  input  1  the execute-stage result is present.
REQ-006 Port: ready_mem_2_exe_o  output  1  this stage accepts an operation this cycle.
REQ-007 Port: opcode_exe_2_mem_i  input  OPC_W  operation code, using the codes LH=0, LB=1, LW=2, LBU=3, LHU=4, SW=5, SH=6, SB=7; any other value is a non-memory operation.
REQ-008 Port: rd_exe_2_mem_i  input  RD_W  destination-register tag.
REQ-009 Port: rd_data_exe_2_mem_i  input  32  ALU result, passed through for non-memory operations.
REQ-010 Port: mem_address_i  input  32  load/store byte address.
REQ-011 Port: mem_data_i  input  32  store data; the low bytes are significant.
REQ-012 Port: dmem_req_o / dmem_we_o  output  1/1  data-memory request / write enable.
REQ-013 Port: dmem_addr_o  output  32  word address; bits [1:0] are always 0.
REQ-014 Port: dmem_be_o  output  4  byte enables.
REQ-015 Port: dmem_wdata_o  output  32  lane-aligned write data.
REQ-016 Port: dmem_gnt_i / dmem_rvalid_i  input  1/1  request accepted / read data valid.
REQ-017 Port: dmem_rdata_i  input  32  read word.
REQ-018 Port: valid_mem_2_wb_o / we_mem_2_wb_o  output  1/1  writeback valid / register write.
REQ-019 Port: rd_mem_2_wb_o  output  RD_W  destination-register tag to writeback.
REQ-020 Port: rd_data_mem_2_wb_o  output  32  writeback data.
REQ-021 Port: misalign_o  output  1  one-cycle misaligned-access pulse.
REQ-022 Port: misalign_addr_o  output  32  faulting address, held until the next misalign.

Function
REQ-023 State machine: IDLE, REQ, WAIT; ready_mem_2_exe_o = 1 only in IDLE.
REQ-024 Accept: transfer occurs when valid_exe_2_mem_i and ready_mem_2_exe_o are both 1; opcode, tag, address and data are latched.
REQ-025 Non-memory operation: next cycle valid=1, we=1, tag and rd_data passed through; state stays IDLE; 1-cycle latency.
REQ-026 Alignment rule: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0; byte ops are always aligned.
REQ-027 Misaligned access: no request is issued; next cycle misalign_o=1, misalign_addr_o=address, valid=1, we=0; state stays IDLE.
REQ-028 Aligned memory operation: go to REQ; hold dmem_req_o=1 with addr/we/be/wdata stable until dmem_gnt_i=1.
REQ-029 Byte enables: SW be=1111; SH be=0011<<(2*addr[1]); SB be=0001<<addr[1:0]; loads be=1111.
REQ-030 Store data: SB replicates byte[7:0] four times; SH replicates half[15:0] twice; SW passes the word through.
REQ-031 Store on grant: in REQ with gnt=1, drop req, go to IDLE; next cycle valid=1, we=0.
REQ-032 Load on grant: in REQ with gnt=1 and rvalid=0, go to WAIT; with gnt=1 and rvalid=1 in the same cycle, complete immediately as in REQ-033.
REQ-033 Load completion: in WAIT with rvalid=1, go to IDLE; next cycle valid=1, we=1, tag, extracted data.
REQ-034 Load extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-035 dmem_rvalid_i is ignored in IDLE.
REQ-036 valid_mem_2_wb_o and misalign_o are single-cycle pulses; the data outputs hold their last value otherwise.

Reset
REQ-037 rstl=0 asynchronously forces state=IDLE, all 1-bit outputs=0 (ready becomes 1 once rstl=1), and all buses=0.
REQ-038 Reset during REQ or WAIT abandons the transaction; no writeback is issued and a late rvalid is ignored.

Verification
REQ-039 Scenario ADD passthrough: opcode=14, rd=5, data=0x1234 -> next cycle valid=1, we=1, rd=5, data=0x1234.
REQ-040 Scenario LB: addr=0x103, rdata=0x80FF_0000, gnt after 2 cycles, rvalid 1 cycle later -> data=0xFFFF_FF80; ready=0 throughout.
REQ-041 Scenario SH: addr=0x202, data=0xABCD -> addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1; then valid=1, we=0.
REQ-042 Scenario LW misaligned: addr=0x301 -> no req, misalign_o=1, misalign_addr=0x301, valid=1, we=0.
REQ-043 Scenario LHU with gnt and rvalid together: addr=0x2, rdata=0xF00D_0000 -> data=0x0000_F00D.
REQ-044 Scenario reset in WAIT: rstl low, then rvalid=1 -> no writeback, state IDLE.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu -- memory stage load/store unit.
//
// Accepts one operation at a time from the execute stage. Non-memory operations
// pass straight through to writeback. A misaligned load or store is turned into a
// misalign pulse and does not issue a request. An aligned load or store drives one
// request on the data-memory port and holds it until it is granted. Loads then wait
// for read data, then extract and extend the addressed byte or halfword.
//
// Ports
//   clk, rstl                      clock, asynchronous active-low reset
//   valid_exe_2_mem_i / ready_mem_2_exe_o   execute-stage handshake
//   opcode/rd/rd_data_exe_2_mem_i  operation, destination tag, ALU result
//   mem_address_i, mem_data_i      byte address and store data
//   dmem_req_o/we_o/addr_o/be_o/wdata_o     data-memory request side
//   dmem_gnt_i/rvalid_i/rdata_i    data-memory response side
//   valid/we/rd/rd_data_mem_2_wb_o writeback outputs (valid is a 1-cycle pulse)
//   misalign_o, misalign_addr_o    misaligned-access pulse and held fault address
module mem_lsu #(
    parameter int OPC_W = 32,
    parameter int RD_W  = 11
) (
    input  logic             clk,
    input  logic             rstl,
    input  logic             valid_exe_2_mem_i,
    output logic             ready_mem_2_exe_o,
    input  logic [OPC_W-1:0] opcode_exe_2_mem_i,
    input  logic [RD_W-1:0]  rd_exe_2_mem_i,
    input  logic [31:0]      rd_data_exe_2_mem_i,
    input  logic [31:0]      mem_address_i,
    input  logic [31:0]      mem_data_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [31:0]      dmem_addr_o,
    output logic [3:0]       dmem_be_o,
    output logic [31:0]      dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [31:0]      dmem_rdata_i,
    output logic             valid_mem_2_wb_o,
    output logic             we_mem_2_wb_o,
    output logic [RD_W-1:0]  rd_mem_2_wb_o,
    output logic [31:0]      rd_data_mem_2_wb_o,
    output logic             misalign_o,
    output logic [31:0]      misalign_addr_o
);

    localparam logic [2:0] OP_LH  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [31:0]      dmem_addr_q, dmem_addr_d;
    logic [3:0]       dmem_be_q, dmem_be_d;
    logic [31:0]      dmem_wdata_q, dmem_wdata_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q, wb_we_d;
    logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             mis_q, mis_d;
    logic [31:0]      mis_addr_q, mis_addr_d;

    // Select the addressed byte/halfword from the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] r;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   r = $signed(b);
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = $signed(h);
            OP_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic [2:0] opc_lo;
    logic       is_mem, is_store, misaligned;
    logic [3:0] be_new;
    logic [31:0] wdata_new;

    always_comb begin
        opc_lo   = opcode_exe_2_mem_i[2:0];
        is_mem   = (opcode_exe_2_mem_i[OPC_W-1:3] == '0);
        is_store = (opc_lo == OP_SW) || (opc_lo == OP_SH) || (opc_lo == OP_SB);
        misaligned = (((opc_lo == OP_LW) || (opc_lo == OP_SW)) && (mem_address_i[1:0] != 2'b00))
                   || (((opc_lo == OP_LH) || (opc_lo == OP_LHU) || (opc_lo == OP_SH))
                       && mem_address_i[0]);
        case (opc_lo)
            OP_SH: begin
                be_new    = mem_address_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{mem_data_i[15:0]}};
            end
            OP_SB: begin
                be_new    = 4'b0001 << mem_address_i[1:0];
                wdata_new = {4{mem_data_i[7:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = mem_data_i;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        rd_d         = rd_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        mis_d        = 1'b0;
        mis_addr_d   = mis_addr_q;

        case (state_q)
            S_IDLE: begin
                // Read data arriving here belongs to no transaction and is dropped.
                if (valid_exe_2_mem_i) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b1;
                        wb_rd_d    = rd_exe_2_mem_i;
                        wb_data_d  = rd_data_exe_2_mem_i;
                    end else if (misaligned) begin
                        mis_d      = 1'b1;
                        mis_addr_d = mem_address_i;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = rd_exe_2_mem_i;
                    end else begin
                        state_d      = S_REQ;
                        op_d         = opc_lo;
                        off_d        = mem_address_i[1:0];
                        rd_d         = rd_exe_2_mem_i;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {mem_address_i[31:2], 2'b00};
                        dmem_be_d    = be_new;
                        dmem_wdata_d = wdata_new;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    dmem_req_d = 1'b0;
                    if (dmem_we_q) begin
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = rd_q;
                    end else if (dmem_rvalid_i) begin
                        // Grant and data in the same cycle: finish without visiting WAIT.
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_extract(op_q, off_q, dmem_rdata_i);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_extract(op_q, off_q, dmem_rdata_i);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            mis_q        <= 1'b0;
            mis_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            mis_q        <= mis_d;
            mis_addr_q   <= mis_addr_d;
        end
    end

    // Held low while reset is asserted so upstream cannot hand over an operation.
    assign ready_mem_2_exe_o  = rstl && (state_q == S_IDLE);
    assign dmem_req_o         = dmem_req_q;
    assign dmem_we_o          = dmem_we_q;
    assign dmem_addr_o        = dmem_addr_q;
    assign dmem_be_o          = dmem_be_q;
    assign dmem_wdata_o       = dmem_wdata_q;
    assign valid_mem_2_wb_o   = wb_valid_q;
    assign we_mem_2_wb_o      = wb_we_q;
    assign rd_mem_2_wb_o      = wb_rd_q;
    assign rd_data_mem_2_wb_o = wb_data_q;
    assign misalign_o         = mis_q;
    assign misalign_addr_o    = mis_addr_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rstl;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] opcode_i;
    logic [10:0] rd_i;
    logic [31:0] rd_data_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        req_o, dwe_o;
    logic [31:0] daddr_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        gnt_i, rvalid_i;
    logic [31:0] rdata_i;
    logic        wb_valid_o, wb_we_o;
    logic [10:0] wb_rd_o;
    logic [31:0] wb_data_o;
    logic        mis_o;
    logic [31:0] mis_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_lsu #(.OPC_W(32), .RD_W(11)) dut (
        .clk                 (clk),
        .rstl                (rstl),
        .valid_exe_2_mem_i   (valid_i),
        .ready_mem_2_exe_o   (ready_o),
        .opcode_exe_2_mem_i  (opcode_i),
        .rd_exe_2_mem_i      (rd_i),
        .rd_data_exe_2_mem_i (rd_data_i),
        .mem_address_i       (addr_i),
        .mem_data_i          (data_i),
        .dmem_req_o          (req_o),
        .dmem_we_o           (dwe_o),
        .dmem_addr_o         (daddr_o),
        .dmem_be_o           (be_o),
        .dmem_wdata_o        (wdata_o),
        .dmem_gnt_i          (gnt_i),
        .dmem_rvalid_i       (rvalid_i),
        .dmem_rdata_i        (rdata_i),
        .valid_mem_2_wb_o    (wb_valid_o),
        .we_mem_2_wb_o       (wb_we_o),
        .rd_mem_2_wb_o       (wb_rd_o),
        .rd_data_mem_2_wb_o  (wb_data_o),
        .misalign_o          (mis_o),
        .misalign_addr_o     (mis_addr_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] opc, input logic [10:0] rd,
                         input logic [31:0] addr, input logic [31:0] data);
        valid_i   = 1'b1;
        opcode_i  = opc;
        rd_i      = rd;
        addr_i    = addr;
        data_i    = data;
        rd_data_i = data;
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        rstl = 1'b0; valid_i = 1'b0; opcode_i = '0; rd_i = '0; rd_data_i = '0;
        addr_i = '0; data_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        #2;
        check("rst_ready",   {31'd0, ready_o},    32'd0);
        check("rst_req",     {31'd0, req_o},      32'd0);
        check("rst_valid",   {31'd0, wb_valid_o}, 32'd0);
        check("rst_misaddr", mis_addr_o,          32'd0);
        check("rst_wbdata",  wb_data_o,           32'd0);
        step();
        rstl = 1'b1;
        step();
        check("idle_ready", {31'd0, ready_o}, 32'd1);

        // ADD passthrough
        issue(32'd14, 11'd5, 32'h0, 32'h1234);
        check("add_valid", {31'd0, wb_valid_o}, 32'd1);
        check("add_we",    {31'd0, wb_we_o},    32'd1);
        check("add_rd",    {21'd0, wb_rd_o},    32'd5);
        check("add_data",  wb_data_o,           32'h1234);
        check("add_noreq", {31'd0, req_o},      32'd0);
        step();
        check("add_pulse", {31'd0, wb_valid_o}, 32'd0);

        // LB at 0x103, grant after two request cycles, data one cycle later
        issue(32'd1, 11'd7, 32'h103, 32'h0);
        check("lb_req",   {31'd0, req_o},   32'd1);
        check("lb_addr",  daddr_o,          32'h100);
        check("lb_be",    {28'd0, be_o},    32'hF);
        check("lb_we",    {31'd0, dwe_o},   32'd0);
        check("lb_rdy1",  {31'd0, ready_o}, 32'd0);
        step();
        check("lb_req2",  {31'd0, req_o},   32'd1);
        check("lb_rdy2",  {31'd0, ready_o}, 32'd0);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check("lb_reqoff", {31'd0, req_o},      32'd0);
        check("lb_rdy3",   {31'd0, ready_o},    32'd0);
        check("lb_novld",  {31'd0, wb_valid_o}, 32'd0);
        rvalid_i = 1'b1; rdata_i = 32'h80FF_0000;
        step();
        rvalid_i = 1'b0;
        check("lb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("lb_wbwe",  {31'd0, wb_we_o},    32'd1);
        check("lb_rd",    {21'd0, wb_rd_o},    32'd7);
        check("lb_data",  wb_data_o,           32'hFFFF_FF80);
        check("lb_ready", {31'd0, ready_o},    32'd1);

        // read data while idle is ignored
        rvalid_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
        step();
        rvalid_i = 1'b0;
        check("idle_rv_valid", {31'd0, wb_valid_o}, 32'd0);
        check("idle_rv_data",  wb_data_o,           32'hFFFF_FF80);

        // SH at 0x202
        issue(32'd6, 11'd3, 32'h202, 32'hABCD);
        check("sh_req",   {31'd0, req_o}, 32'd1);
        check("sh_we",    {31'd0, dwe_o}, 32'd1);
        check("sh_addr",  daddr_o,        32'h200);
        check("sh_be",    {28'd0, be_o},  32'hC);
        check("sh_wdata", wdata_o,        32'hABCD_ABCD);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check("sh_valid", {31'd0, wb_valid_o}, 32'd1);
        check("sh_wbwe",  {31'd0, wb_we_o},    32'd0);
        check("sh_reqoff",{31'd0, req_o},      32'd0);
        check("sh_hold",  wb_data_o,           32'hFFFF_FF80);

        // SB at 0x1
        issue(32'd7, 11'd4, 32'h1, 32'h1234_565A);
        check("sb_be",    {28'd0, be_o}, 32'h2);
        check("sb_wdata", wdata_o,       32'h5A5A_5A5A);
        check("sb_addr",  daddr_o,       32'h0);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check("sb_valid", {31'd0, wb_valid_o}, 32'd1);

        // LW misaligned
        issue(32'd2, 11'd6, 32'h301, 32'h0);
        check("mis_noreq", {31'd0, req_o},      32'd0);
        check("mis_pulse", {31'd0, mis_o},      32'd1);
        check("mis_addr",  mis_addr_o,          32'h301);
        check("mis_valid", {31'd0, wb_valid_o}, 32'd1);
        check("mis_we",    {31'd0, wb_we_o},    32'd0);
        check("mis_ready", {31'd0, ready_o},    32'd1);
        step();
        check("mis_off",   {31'd0, mis_o},      32'd0);
        check("mis_hold",  mis_addr_o,          32'h301);

        // LHU at 0x2 with grant and data together
        issue(32'd4, 11'd9, 32'h2, 32'h0);
        check("lhu_be", {28'd0, be_o}, 32'hF);
        gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'hF00D_0000;
        step();
        gnt_i = 1'b0; rvalid_i = 1'b0;
        check("lhu_valid", {31'd0, wb_valid_o}, 32'd1);
        check("lhu_rd",    {21'd0, wb_rd_o},    32'd9);
        check("lhu_data",  wb_data_o,           32'h0000_F00D);

        // LH at 0x0, negative halfword sign-extends
        issue(32'd0, 11'd2, 32'h0, 32'h0);
        gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h1234_8001;
        step();
        gnt_i = 1'b0; rvalid_i = 1'b0;
        check("lh_data", wb_data_o, 32'hFFFF_8001);

        // Reset while waiting for load data
        issue(32'd2, 11'd8, 32'h400, 32'h0);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check("rw_ready_wait", {31'd0, ready_o}, 32'd0);
        rstl = 1'b0;
        #1;
        check("rw_async_req", {31'd0, req_o},   32'd0);
        check("rw_async_rdy", {31'd0, ready_o}, 32'd0);
        step();
        rstl = 1'b1;
        rvalid_i = 1'b1; rdata_i = 32'h5555_AAAA;
        step();
        rvalid_i = 1'b0;
        check("rw_novalid", {31'd0, wb_valid_o}, 32'd0);
        check("rw_ready",   {31'd0, ready_o},    32'd1);
        check("rw_data",    wb_data_o,           32'd0);
        step();
        check("rw_novalid2", {31'd0, wb_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
